// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: enable, shadow-load port and per-channel q/tick/pend.
// The sync input only exists when CLKDIV_SYNC_EN is defined.
interface clk_div_gen_if #(
  parameter int N  = 26,
  parameter int CH = 4,
  parameter int CW = 2
);
  logic          en;
  logic          load;
  logic [CW-1:0] load_ch;
  logic [N-1:0]  load_div;
  logic [N-1:0]  load_hi;
`ifdef CLKDIV_SYNC_EN
  logic          sync;
`endif
  logic [CH-1:0] q;
  logic [CH-1:0] tick;
  logic [CH-1:0] pend;

`ifdef CLKDIV_SYNC_EN
  modport master (output en, load, load_ch, load_div, load_hi, sync, input q, tick, pend);
  modport slave  (input en, load, load_ch, load_div, load_hi, sync, output q, tick, pend);
`else
  modport master (output en, load, load_ch, load_div, load_hi, input q, tick, pend);
  modport slave  (input en, load, load_ch, load_div, load_hi, output q, tick, pend);
`endif
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel divider: per-channel wrap counter, duty square wave q, wrap tick, shadow reload.
// Load always accepted; q is combinational from registers, tick/pend registered. CLKDIV_SYNC_EN adds sync realign.
module clk_div_gen #(
  parameter int          N           = 26,
  parameter int          CH          = 4,
  parameter int          CW          = 2,
  parameter int unsigned DIV_DEFAULT = 49999999,
  parameter int unsigned HI_DEFAULT  = 25000000
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_gen_if.slave bus
);

  logic [N-1:0]  cnt_q  [CH];
  logic [N-1:0]  cnt_d  [CH];
  logic [N-1:0]  div_q  [CH];
  logic [N-1:0]  div_d  [CH];
  logic [N-1:0]  hi_q   [CH];
  logic [N-1:0]  hi_d   [CH];
  logic [N-1:0]  sdiv_q [CH];
  logic [N-1:0]  sdiv_d [CH];
  logic [N-1:0]  shi_q  [CH];
  logic [N-1:0]  shi_d  [CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] tick_q, tick_d;
  logic [CH-1:0] sq_w;
  logic          sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = bus.sync;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      hi_d[i]   = hi_q[i];
      sdiv_d[i] = sdiv_q[i];
      shi_d[i]  = shi_q[i];
      pend_d[i] = pend_q[i];
      tick_d[i] = 1'b0;

      if (sync_w) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_d[i]  = sdiv_q[i];
          hi_d[i]   = shi_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (bus.en) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          // Shadow is only promoted at a period boundary so q never glitches mid-period.
          if (pend_q[i]) begin
            div_d[i]  = sdiv_q[i];
            hi_d[i]   = shi_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + N'(1);
        end
      end

      // Placed after the apply so a load coinciding with a wrap stays pending.
      if (bus.load && (bus.load_ch == CW'(i))) begin
        sdiv_d[i] = bus.load_div;
        shi_d[i]  = bus.load_hi;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= N'(DIV_DEFAULT);
        hi_q[i]   <= N'(HI_DEFAULT);
        sdiv_q[i] <= N'(DIV_DEFAULT);
        shi_q[i]  <= N'(HI_DEFAULT);
      end
      pend_q <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        hi_q[i]   <= hi_d[i];
        sdiv_q[i] <= sdiv_d[i];
        shi_q[i]  <= shi_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    sq_w = '0;
    for (int i = 0; i < CH; i++) begin
      sq_w[i] = (cnt_q[i] >= hi_q[i]);
    end
  end

  assign bus.q    = sq_w;
  assign bus.tick = tick_q;
  assign bus.pend = pend_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen (N=4, CH=2, div=9, hi=5 defaults) with a per-cycle reference model.
// Compile with CLKDIV_SYNC_EN to include the sync realign scenario.
module tb_clk_div_gen;
  localparam int N = 4, CH = 2, CW = 2, DIVD = 9, HID = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;

  clk_div_gen_if #(.N(N), .CH(CH), .CW(CW)) bus ();

  clk_div_gen #(
    .N(N), .CH(CH), .CW(CW), .DIV_DEFAULT(DIVD), .HI_DEFAULT(HID)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference: phase within the current period, active and shadow period settings.
  int m_phase [CH];
  int m_div   [CH];
  int m_hi    [CH];
  int m_sdiv  [CH];
  int m_shi   [CH];
  bit m_pend  [CH];
  bit m_tick  [CH];
  bit m_sync;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_phase[c] = 0;
        m_div[c]   = DIVD;
        m_hi[c]    = HID;
        m_sdiv[c]  = DIVD;
        m_shi[c]   = HID;
        m_pend[c]  = 1'b0;
        m_tick[c]  = 1'b0;
      end
    end else begin
      m_sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
      m_sync = bus.sync;
`endif
      for (int c = 0; c < CH; c++) begin
        m_tick[c] = 1'b0;
        if (m_sync || (bus.en && m_phase[c] == m_div[c])) begin
          m_tick[c]  = !m_sync;
          m_phase[c] = 0;
          if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_hi[c]   = m_shi[c];
            m_pend[c] = 1'b0;
          end
        end else if (bus.en) begin
          m_phase[c] = m_phase[c] + 1;
        end
        if (bus.load && int'(bus.load_ch) == c) begin
          m_sdiv[c] = int'(bus.load_div);
          m_shi[c]  = int'(bus.load_hi);
          m_pend[c] = 1'b1;
        end
      end
    end
  end

  logic [CH-1:0] e_q, e_t, e_p;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        e_q[c] = (m_phase[c] >= m_hi[c]);
        e_t[c] = m_tick[c];
        e_p[c] = m_pend[c];
      end
      check("model_q", 32'(bus.q), 32'(e_q));
      check("model_tick", 32'(bus.tick), 32'(e_t));
      check("model_pend", 32'(bus.pend), 32'(e_p));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_load(input int ch, input int dv, input int hv);
    bus.load     = 1'b1;
    bus.load_ch  = CW'(ch);
    bus.load_div = N'(dv);
    bus.load_hi  = N'(hv);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int waited);
    waited = 0;
    while (bus.tick[ch] !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > maxc) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_tick: ch%0d no tick within %0d cycles", ch, maxc);
        break;
      end
    end
  endtask

  int first_tick, first_rise, hi_cnt, w, guard;
  logic [3:0] seq;
  bit tick_seen;

  initial begin
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.load_ch = '0;
    bus.load_div = '0;
    bus.load_hi = '0;
`ifdef CLKDIV_SYNC_EN
    bus.sync = 1'b0;
`endif
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_pend", 32'(bus.pend), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    bus.en = 1'b1;

    // Default 10-cycle period, q low for cnt 0..4 and high for 5..9.
    first_tick = -1; first_rise = -1; hi_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.tick[0] && first_tick < 0) first_tick = k;
      if (bus.q[0] && first_rise < 0) first_rise = k;
      if (bus.q[0]) hi_cnt++;
    end
    check("first_tick_cycle", 32'(first_tick), 32'd10);
    check("first_q_rise", 32'(first_rise), 32'd5);
    check("q_high_cycles_20", 32'(hi_cnt), 32'd10);

    // Mid-period reload of ch1 to div=3 hi=2.
    repeat (3) @(negedge clk);
    do_load(1, 3, 2);
    check("pend_after_load", 32'(bus.pend), 32'b10);
    wait_tick(1, 12, w);
    check("pend_after_apply", 32'(bus.pend[1]), 32'd0);
    check("ch0_tick_with_ch1", 32'(bus.tick[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      seq[3-k] = bus.q[1];
    end
    check("ch1_q_seq", 32'(seq), 32'b0011);

    // ch1 is at cnt=3: this load lands on the wrap edge.
    do_load(1, 5, 7);
    check("tick_at_wrap_load", 32'(bus.tick[1]), 32'd1);
    check("pend_held_on_wrap", 32'(bus.pend[1]), 32'd1);
    @(negedge clk);
    wait_tick(1, 8, w);
    check("wrap_load_delay", 32'(w), 32'd3);
    @(negedge clk);
    wait_tick(1, 10, w);
    check("div5_period", 32'(w + 1), 32'd6);
    check("hi_gt_div_q", 32'(bus.q[1]), 32'd0);

    // div=0 hi=0 on ch0.
    do_load(0, 0, 0);
    guard = 0;
    while (bus.pend[0] === 1'b1 && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    check("ch0_pend_cleared", 32'(bus.pend[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("div0_q", 32'(bus.q[0]), 32'd1);
    check("div0_tick", 32'(bus.tick[0]), 32'd1);

    // Out-of-range channel is ignored.
    repeat (12) @(negedge clk);
    do_load(3, 1, 1);
    check("ignored_load_pend", 32'(bus.pend), 32'd0);

    // en low for 7 cycles stretches ch1 period 6 -> 13.
    @(negedge clk);
    wait_tick(1, 10, w);
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    tick_seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      tick_seen |= |bus.tick;
    end
    bus.en = 1'b1;
    wait_tick(1, 20, w);
    check("tick_while_en_low", 32'(tick_seen), 32'd0);
    check("stretched_period", 32'(2 + 7 + w), 32'd13);

    // Asynchronous reset with a load pending.
    do_load(1, 9, 5);
    check("pend_before_reset", 32'(bus.pend[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_q", 32'(bus.q), 32'd0);
    check("async_rst_tick", 32'(bus.tick), 32'd0);
    check("async_rst_pend", 32'(bus.pend), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);

`ifdef CLKDIV_SYNC_EN
    // Desynchronise the channels, then realign with sync while ch1 loads.
    do_load(0, 3, 1);
    repeat (12) @(negedge clk);
    do_load(0, 6, 3);
    bus.sync = 1'b1;
    do_load(1, 7, 2);
    bus.sync = 1'b0;
    check("sync_pend", 32'(bus.pend), 32'b10);
    check("sync_tick", 32'(bus.tick), 32'd0);
    check("sync_q", 32'(bus.q), 32'd0);
    repeat (20) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Multi-channel programmable clock-enable / square-wave generator. Each of `CH` channels runs its own wrap-around counter and produces a duty-programmable square wave `q` and a one-cycle `tick` at every wrap. It is the generalised successor of the fixed single-channel divider that derives 1 Hz from the 50 MHz board clock. Period and duty are reloadable at run time, glitch-free, through a shadow-register load port. It feeds display multiplexers, blinkers and counter-enable inputs across the design.

## Interface
- `N`, 26: counter, divisor and duty width.
- `CH`, 4: number of channels (≥1).
- `CW`, 2: channel-select width, ≥ max(1, clog2(CH)).
- `DIV_DEFAULT`, 49999999: reset terminal count; period = div+1 cycles (1 Hz at 50 MHz).
- `HI_DEFAULT`, 25000000: reset duty threshold.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `en`  in  1  global count enable.
- `load`  in  1  one-cycle load strobe.
- `load_ch`  in  CW  channel addressed by `load`.
- `load_div`  in  N  new terminal count.
- `load_hi`  in  N  new duty threshold.
- `sync`  in  1  phase realign; present only with `CLKDIV_SYNC_EN`.
- `q`  out  CH  per-channel square wave.
- `tick`  out  CH  per-channel one-cycle wrap pulse.
- `pend`  out  CH  per-channel reload-pending flag.

## Operation
- Per-channel state: `cnt`[N], active `div`/`hi`[N], shadow `sdiv`/`shi`[N], `pend`, `tick` register.
- Reset: cnt=0, div=sdiv=DIV_DEFAULT, hi=shi=HI_DEFAULT, pend=0, tick=0.
- Count: if en and cnt≠div, cnt+1. If en and cnt==div, it wraps: cnt←0, tick←1. Otherwise tick←0. If en=0, cnt holds and tick←0.
- Square wave: q = (cnt ≥ hi), unsigned compare, combinational from registers.
  - hi=0 → q constant 1.
  - hi>div → q constant 0.
  - hi=(div+1)/2 with div odd → exact 50 %.
- div=0: cnt stays 0 and wraps every enabled cycle. tick is constantly 1 while en=1.
- Load: on `load` with load_ch<CH: sdiv←load_div, shi←load_hi, pend←1 for that channel. load_ch≥CH is ignored.
- Apply: at a wrap edge with pend=1: div←sdiv, hi←shi, pend←0. Active values never change mid-period.
- Load on the same edge as a wrap of that channel: the wrap applies the previous shadow (if pend). The new values are written to the shadow and pend stays 1.
- Load while pend=1 overwrites the shadow (last write wins).
- With en=0, pending loads remain pending until the next enabled wrap.
- Channels are fully independent except for the shared `en`, load port and `sync`.

## Timing
- Period = div+1 enabled cycles. Duty high time = div+1−hi cycles when hi≤div.
- `tick` is high in the cycle where cnt==0 following a wrap. It is never high directly after reset.
- `pend` rises the cycle after `load` and falls the cycle after the applying wrap.
- New div/hi first affect q in the cycle where cnt==0 after the wrap.
- Reset mid-period: all outputs return immediately (asynchronously) to reset values and pending loads are discarded. After reset, q = (0 ≥ HI_DEFAULT).
- Precedence: reset > sync > wrap/count; load writes the shadow independently.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - `sync` port exists. On an edge with sync=1, every channel gets cnt←0 and tick←0.
  - Any pending shadow is applied immediately (div←sdiv, hi←shi, pend←0). A load in the same cycle remains pending.
  - sync acts regardless of `en`.
- `CLKDIV_SYNC_EN` undefined: no `sync` port and no realign logic. Channels realign only via reset.

## Test plan
- N=4, CH=2, DIV_DEFAULT=9, HI_DEFAULT=5, en=1 after reset:
  - q of both channels = 0 for 5 cycles, then 1 for 5 cycles, repeating.
  - tick pulses every 10 cycles, first at cycle 10.
- Load ch1 div=3, hi=2 mid-period: pend[1]=1 next cycle. Channel 1 finishes its 10-cycle period, then runs period 4 (q 0,0,1,1) and pend[1]=0. Channel 0 is unchanged.
- Edge cases:
  - div=0, hi=0 → tick and q constant 1.
  - div=5, hi=7 → q constant 0, tick every 6 cycles.
  - load_ch=3 with CH=2 → no pend, no change.
- Timing collisions:
  - en low for 7 cycles mid-period: cnt, q hold and tick=0. The period stretches by exactly 7 cycles.
  - Load on the wrap edge: the new value is applied one period later.
  - Reset asserted mid-count with pend=1: outputs immediately revert to reset values and pend=0.
- With `CLKDIV_SYNC_EN`: channels at differing phases, pulse sync. Both cnt=0 next cycle, q and tick identical from then on, and a pending load is applied at once.
